// File: rtl/dvs_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the DVS control block.
package dvs_ctrl_pkg;

  localparam int         DAC_WIDTH_DEF   = 12;
  localparam int         NUM_DACS_DEF    = 8;
  localparam int         FIFO_AWIDTH_DEF = 10;
  localparam logic [7:0] CHIP_ID_DEF     = 8'h55;

  // Command byte fields
  localparam int         CMD_READ_BIT = 7;
  localparam logic [1:0] SIZE_BT      = 2'd0;
  localparam logic [1:0] SIZE_HW      = 2'd1;
  localparam logic [1:0] SIZE_WD      = 2'd2;

  // Register map (byte addresses)
  localparam logic [6:0] ADDR_CHIP_ID      = 7'd0;
  localparam logic [6:0] ADDR_FIFO_CTRL    = 7'd1;
  localparam logic [6:0] ADDR_IRQ_DEASSERT = 7'd12;
  localparam logic [6:0] ADDR_IRQ_ASSERT   = 7'd14;
  localparam logic [6:0] ADDR_FIFO_NUMEL   = 7'd16;
  localparam logic [6:0] ADDR_FIFO_POP     = 7'd18;
  localparam logic [6:0] ADDR_DAC_BASE     = 7'd20;
  localparam logic [6:0] ADDR_BIAS_BASE    = 7'd112;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA
  } qspi_state_t;

  // Number of bytes moved by a transfer of the given size code
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BT: return 3'd1;
      SIZE_HW: return 3'd2;
      SIZE_WD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Clear the low address bits so halfwords and words are naturally aligned
  function automatic logic [6:0] align_addr(input logic [6:0] a, input logic [1:0] size);
    case (size)
      SIZE_HW: return {a[6:1], 1'b0};
      SIZE_WD: return {a[6:2], 2'b00};
      default: return a;
    endcase
  endfunction

  // True when the transfer starting at a touches byte target
  function automatic logic covers(input logic [6:0] a, input logic [1:0] size,
                                  input logic [6:0] target);
    return (target >= a) && ({1'b0, target} < ({1'b0, a} + 8'(size_bytes(size))));
  endfunction

endpackage

// File: rtl/dvs_ctrl_qspi_target.sv
// Quad-lane SPI target: pin synchronizers, frame sequencer and nibble shifters.
module qspi_target
  import dvs_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        sck,
  input  logic [3:0]  copi,
  output logic [3:0]  cipo,
  output logic [6:0]  addr,
  output logic [1:0]  size,
  output logic [31:0] wdata,
  output logic        wr_strobe,
  output logic        rd_strobe,
  input  logic [31:0] rdata
);

  logic        cs_meta, cs_s;
  logic        sck_meta, sck_s, sck_d;
  logic [3:0]  copi_meta, copi_s;
  logic        sck_rise, sck_fall;
  qspi_state_t state;
  logic [3:0]  nib_cnt;
  logic [3:0]  last_nib;
  logic        is_read;
  logic        done;
  logic [2:0]  addr_hi;
  logic [27:0] wshift;
  logic [31:0] rshift;
  logic [31:0] rdata_msb;

  // Two-flop synchronizers for all SPI pins plus a delayed SCK for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta   <= 1'b1;
      cs_s      <= 1'b1;
      sck_meta  <= 1'b0;
      sck_s     <= 1'b0;
      sck_d     <= 1'b0;
      copi_meta <= '0;
      copi_s    <= '0;
    end else begin
      cs_meta   <= cs_n;
      cs_s      <= cs_meta;
      sck_meta  <= sck;
      sck_s     <= sck_meta;
      sck_d     <= sck_s;
      copi_meta <= copi;
      copi_s    <= copi_meta;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign last_nib = {size_bytes(size), 1'b0} - 4'd1;

  // Left-justify read data so the first nibble out is always bits [31:28]
  always_comb begin
    case (size)
      SIZE_HW: rdata_msb = {rdata[15:0], 16'h0000};
      SIZE_WD: rdata_msb = rdata;
      default: rdata_msb = {rdata[7:0], 24'h000000};
    endcase
  end

  // Frame sequencer: command, address, then write shift-in or read shift-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      nib_cnt   <= '0;
      is_read   <= 1'b0;
      done      <= 1'b0;
      addr_hi   <= '0;
      addr      <= '0;
      size      <= SIZE_BT;
      wshift    <= '0;
      rshift    <= '0;
      wdata     <= '0;
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      cipo      <= '0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      if (cs_s) begin
        state <= ST_IDLE;
        cipo  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_CMD;
            nib_cnt <= '0;
            done    <= 1'b0;
            wshift  <= '0;
            cipo    <= '0;
          end
          ST_CMD: begin
            if (sck_rise) begin
              if (nib_cnt == 4'd0) begin
                is_read <= copi_s[CMD_READ_BIT-4];
                nib_cnt <= 4'd1;
              end else begin
                size    <= copi_s[1:0];
                nib_cnt <= '0;
                state   <= ST_ADDR;
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              if (nib_cnt == 4'd0) begin
                addr_hi <= copi_s[2:0];
                nib_cnt <= 4'd1;
              end else begin
                addr    <= align_addr({addr_hi, copi_s}, size);
                nib_cnt <= '0;
                if (is_read) begin
                  state     <= ST_RDATA;
                  rd_strobe <= 1'b1;
                end else begin
                  state <= ST_WDATA;
                end
              end
            end
          end
          ST_WDATA: begin
            if (sck_rise && !done) begin
              wshift <= {wshift[23:0], copi_s};
              if (nib_cnt == last_nib) begin
                wdata     <= {wshift, copi_s};
                wr_strobe <= 1'b1;
                done      <= 1'b1;
              end else begin
                nib_cnt <= nib_cnt + 4'd1;
              end
            end
          end
          ST_RDATA: begin
            if (sck_fall) begin
              if (nib_cnt == 4'd0) begin
                cipo    <= rdata_msb[31:28];
                rshift  <= {rdata_msb[27:0], 4'h0};
                nib_cnt <= 4'd1;
              end else begin
                cipo   <= rshift[31:28];
                rshift <= {rshift[27:0], 4'h0};
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/dvs_ctrl_top.sv
// DVS chip control: SPI target front-end, byte-addressable register file and output decode.
module dvs_ctrl_top
  import dvs_ctrl_pkg::*;
#(
  parameter int         DAC_WIDTH   = DAC_WIDTH_DEF,
  parameter int         NUM_DACS    = NUM_DACS_DEF,
  parameter int         FIFO_AWIDTH = FIFO_AWIDTH_DEF,
  parameter logic [7:0] CHIP_ID     = CHIP_ID_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   CS_N,
  input  logic                   SCK,
  input  logic [3:0]             COPI,
  output logic [3:0]             CIPO,
  output logic [23:0]            bias_0,
  output logic [23:0]            bias_1,
  output logic [23:0]            bias_2,
  output logic [23:0]            bias_3,
  output logic                   we_out,
  output logic [DAC_WIDTH-1:0]   dac_config_0,
  output logic [DAC_WIDTH-1:0]   dac_config_1,
  output logic [DAC_WIDTH-1:0]   dac_config_2,
  output logic [DAC_WIDTH-1:0]   dac_config_3,
  output logic [DAC_WIDTH-1:0]   dac_config_4,
  output logic [DAC_WIDTH-1:0]   dac_config_5,
  output logic [DAC_WIDTH-1:0]   dac_config_6,
  output logic [DAC_WIDTH-1:0]   dac_config_7,
  output logic [FIFO_AWIDTH-1:0] irq_assert_thresh,
  output logic [FIFO_AWIDTH-1:0] irq_deassert_thresh,
  input  logic [FIFO_AWIDTH-1:0] fifo_numel,
  output logic                   fifo_rd_en,
  output logic                   fifo_rst_n
);

  logic [7:0]           mem [128];
  logic [6:0]           addr;
  logic [1:0]           size;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 wr_strobe;
  logic                 rd_strobe;
  logic [2:0]           nbytes;
  logic [15:0]          numel_ext;
  logic                 ctrl_bit0;
  logic [DAC_WIDTH-1:0] dac_q [NUM_DACS];
  logic [23:0]          bias_q [4];

  qspi_target u_qspi (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (CS_N),
    .sck      (SCK),
    .copi     (COPI),
    .cipo     (CIPO),
    .addr     (addr),
    .size     (size),
    .wdata    (wdata),
    .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe),
    .rdata    (rdata)
  );

  assign nbytes    = size_bytes(size);
  assign numel_ext = 16'(fifo_numel);
  // Byte 1 sits at offset 0 of a byte write and offset 1 of any wider aligned write
  assign ctrl_bit0 = addr[0] ? wdata[0] : wdata[8];

  // Bytes with special meaning never take RAM writes
  function automatic logic writable(input logic [6:0] a);
    return !(a == ADDR_CHIP_ID || a == ADDR_FIFO_CTRL || a == ADDR_FIFO_NUMEL ||
             a == ADDR_FIFO_NUMEL + 7'd1 || a == ADDR_FIFO_POP);
  endfunction

  function automatic logic [7:0] read_byte(input logic [6:0] a);
    case (a)
      ADDR_CHIP_ID:           return CHIP_ID;
      ADDR_FIFO_CTRL:         return 8'h00;
      ADDR_FIFO_NUMEL:        return numel_ext[7:0];
      ADDR_FIFO_NUMEL + 7'd1: return numel_ext[15:8];
      ADDR_FIFO_POP:          return 8'h00;
      default:                return mem[a];
    endcase
  endfunction

  // Gather the addressed bytes little-endian into the read word
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes) rdata[8*k +: 8] = read_byte(addr + 7'(k));
    end
  end

  // Register file byte writes on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else if (wr_strobe) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes && writable(addr + 7'(k))) mem[addr + 7'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  // One-clock control strobes derived from committed writes and read starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_out     <= 1'b0;
      fifo_rd_en <= 1'b0;
      fifo_rst_n <= 1'b0;
    end else begin
      we_out     <= wr_strobe;
      fifo_rd_en <= rd_strobe && covers(addr, size, ADDR_FIFO_POP);
      fifo_rst_n <= !(wr_strobe && covers(addr, size, ADDR_FIFO_CTRL) && ctrl_bit0);
    end
  end

  // Registered copies of the configuration fields for the analog and FIFO blocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_deassert_thresh <= '0;
      irq_assert_thresh   <= '0;
      for (int i = 0; i < NUM_DACS; i++) dac_q[i] <= '0;
      for (int i = 0; i < 4; i++) bias_q[i] <= '0;
    end else begin
      irq_deassert_thresh <= FIFO_AWIDTH'({mem[ADDR_IRQ_DEASSERT + 7'd1], mem[ADDR_IRQ_DEASSERT]});
      irq_assert_thresh   <= FIFO_AWIDTH'({mem[ADDR_IRQ_ASSERT + 7'd1], mem[ADDR_IRQ_ASSERT]});
      for (int i = 0; i < NUM_DACS; i++) begin
        dac_q[i] <= DAC_WIDTH'({mem[ADDR_DAC_BASE + 7'(2*i) + 7'd1], mem[ADDR_DAC_BASE + 7'(2*i)]});
      end
      for (int i = 0; i < 4; i++) begin
        bias_q[i] <= {mem[ADDR_BIAS_BASE + 7'(4*i) + 7'd2], mem[ADDR_BIAS_BASE + 7'(4*i) + 7'd1],
                      mem[ADDR_BIAS_BASE + 7'(4*i)]};
      end
    end
  end

  assign dac_config_0 = dac_q[0];
  assign dac_config_1 = dac_q[1];
  assign dac_config_2 = dac_q[2];
  assign dac_config_3 = dac_q[3];
  assign dac_config_4 = dac_q[4];
  assign dac_config_5 = dac_q[5];
  assign dac_config_6 = dac_q[6];
  assign dac_config_7 = dac_q[7];
  assign bias_0 = bias_q[0];
  assign bias_1 = bias_q[1];
  assign bias_2 = bias_q[2];
  assign bias_3 = bias_q[3];

endmodule

// File: tb/tb_dvs_ctrl_top.sv
// Self-checking bench for dvs_ctrl_top: SPI controller driver, passive read monitor and byte-map model.
module tb_dvs_ctrl_top;

  localparam int DW = 12;
  localparam int FW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CS_N = 1'b1;
  logic          SCK = 1'b0;
  logic [3:0]    COPI = 4'h0;
  logic [3:0]    CIPO;
  logic [23:0]   bias [4];
  logic [DW-1:0] dac [8];
  logic          we_out;
  logic [FW-1:0] irq_as, irq_de;
  logic [FW-1:0] numel = '0;
  logic          fifo_rd_en, fifo_rst_n;

  int checks = 0;
  int failures = 0;

  logic [7:0]  model_mem [128];
  logic [31:0] exp_q [$];
  int exp_we = 0, exp_rst_low = 0, exp_rd_en = 0;
  int we_cnt = 0, rst_low_cnt = 0, rd_en_cnt = 0;
  bit count_en = 1'b0;

  dvs_ctrl_top dut (
    .clk(clk), .rst_n(rst_n), .CS_N(CS_N), .SCK(SCK), .COPI(COPI), .CIPO(CIPO),
    .bias_0(bias[0]), .bias_1(bias[1]), .bias_2(bias[2]), .bias_3(bias[3]),
    .we_out(we_out),
    .dac_config_0(dac[0]), .dac_config_1(dac[1]), .dac_config_2(dac[2]), .dac_config_3(dac[3]),
    .dac_config_4(dac[4]), .dac_config_5(dac[5]), .dac_config_6(dac[6]), .dac_config_7(dac[7]),
    .irq_assert_thresh(irq_as), .irq_deassert_thresh(irq_de),
    .fifo_numel(numel), .fifo_rd_en(fifo_rd_en), .fifo_rst_n(fifo_rst_n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] s);
    return (s == 2'd2) ? 4 : (s == 2'd1) ? 2 : 1;
  endfunction

  // What a byte reads as, from the address map description
  function automatic logic [7:0] model_byte(input int b);
    logic [15:0] n16;
    n16 = 16'(numel);
    if (b == 0) return 8'h55;
    if (b == 1 || b == 18) return 8'h00;
    if (b == 16) return n16[7:0];
    if (b == 17) return n16[15:8];
    return model_mem[b];
  endfunction

  function automatic logic [31:0] model_read(input int a, input logic [1:0] s);
    int n = nbytes_of(s);
    int base = a - (a % n);
    logic [31:0] v = 0;
    for (int k = 0; k < n; k++) v = v | (32'(model_byte(base + k)) << (8 * k));
    return v;
  endfunction

  function automatic logic [31:0] mem_le(input int b, input int n);
    logic [31:0] v = 0;
    for (int k = 0; k < n; k++) v = v | (32'(model_mem[b + k]) << (8 * k));
    return v;
  endfunction

  task automatic model_write(input int a, input logic [1:0] s, input logic [31:0] d);
    int n = nbytes_of(s);
    int base = a - (a % n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] byte_val = 8'((d >> (8 * k)) & 32'hff);
      if (base + k != 0) model_mem[base + k] = byte_val;
      if (base + k == 1 && byte_val[0]) exp_rst_low++;
    end
    exp_we++;
  endtask

  // One SPI frame; abort_at > 0 raises CS_N after that many nibbles
  task automatic applyStimulus(input bit rd, input logic [1:0] s, input int a,
                               input logic [31:0] d, input int abort_at);
    int n = 2 * nbytes_of(s);
    int total = 4 + n;
    int limit = (abort_at > 0) ? abort_at : total;
    int base = a - (a % nbytes_of(s));
    logic [7:0] cmd = {rd, 5'($urandom_range(0, 31)), s};
    logic [7:0] ab = {1'($urandom_range(0, 1)), 7'(a)};
    logic [3:0] nib;
    if (abort_at == 0) begin
      if (rd) begin
        exp_q.push_back(model_read(a, s));
        if (base <= 18 && 18 < base + nbytes_of(s)) exp_rd_en++;
      end else begin
        model_write(a, s, d);
      end
    end
    @(negedge clk);
    CS_N = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < limit; j++) begin
      case (j)
        0: nib = cmd[7:4];
        1: nib = cmd[3:0];
        2: nib = ab[7:4];
        3: nib = ab[3:0];
        default: nib = rd ? 4'h0 : 4'((d >> (4 * (n - 1 - (j - 4)))) & 32'hf);
      endcase
      COPI = nib;
      repeat (8) @(negedge clk);
      SCK = 1'b1;
      repeat (8) @(negedge clk);
      SCK = 1'b0;
    end
    COPI = 4'h0;
    repeat (4) @(negedge clk);
    CS_N = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s dac_config_%0d", tag, i), 32'(dac[i]),
                  mem_le(20 + 2 * i, 2) & 32'hfff);
    checkOutput({tag, " irq_deassert"}, 32'(irq_de), mem_le(12, 2) & 32'h3ff);
    checkOutput({tag, " irq_assert"}, 32'(irq_as), mem_le(14, 2) & 32'h3ff);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s bias_%0d", tag, i), 32'(bias[i]), mem_le(112 + 4 * i, 3));
    checkOutput({tag, " we_out_cycles"}, 32'(we_cnt), 32'(exp_we));
    checkOutput({tag, " fifo_rst_low_cycles"}, 32'(rst_low_cnt), 32'(exp_rst_low));
    checkOutput({tag, " fifo_rd_en_cycles"}, 32'(rd_en_cnt), 32'(exp_rd_en));
    checkOutput({tag, " fifo_rst_n_idle"}, 32'(fifo_rst_n), 32'd1);
    checkOutput({tag, " cipo_cs_high"}, 32'(CIPO), 32'd0);
  endtask

  // Strobe width counters, sampled mid-cycle
  always @(negedge clk) begin
    if (count_en) begin
      if (we_out) we_cnt++;
      if (!fifo_rst_n) rst_low_cnt++;
      if (fifo_rd_en) rd_en_cnt++;
    end
  end

  // Passive monitor: decodes each frame from the pins and scores read data
  initial begin : monitor
    int c = 0;
    int n;
    bit m_read = 1'b0;
    bit hdr_bad = 1'b0;
    logic [1:0] m_size = 2'd0;
    logic [31:0] m_acc = 0;
    forever begin
      @(posedge SCK or posedge CS_N);
      if (CS_N) begin
        c = 0;
        hdr_bad = 1'b0;
        m_acc = 0;
      end else begin
        if (c < 4 && CIPO !== 4'h0) hdr_bad = 1'b1;
        if (c == 0) m_read = COPI[3];
        if (c == 1) m_size = COPI[1:0];
        if (c == 3) checkOutput("cipo_zero_in_header", 32'(hdr_bad), 32'd0);
        n = 2 * nbytes_of(m_size);
        if (c >= 4 && m_read && c < 4 + n) begin
          m_acc = {m_acc[27:0], CIPO};
          if (c == 3 + n) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL read_data: got 0x%0h, expected nothing queued", m_acc);
            end else begin
              checkOutput("read_data", m_acc, exp_q.pop_front());
            end
          end
        end
        c++;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int we0, rst0;
    for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
    numel = FW'($urandom_range(0, 1023));
    repeat (5) @(negedge clk);
    checkOutput("fifo_rst_n_in_reset", 32'(fifo_rst_n), 32'd0);
    checkOutput("cipo_in_reset", 32'(CIPO), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    count_en = 1'b1;
    checkAll("reset");

    // Chip ID and FIFO reset strobe
    applyStimulus(1'b1, 2'd0, 0, 0, 0);
    we0 = we_cnt;
    rst0 = rst_low_cnt;
    applyStimulus(1'b0, 2'd0, 1, 32'h01, 0);
    checkOutput("fifo_rst_pulse_len", 32'(rst_low_cnt - rst0), 32'd1);
    checkOutput("we_out_pulse_len", 32'(we_cnt - we0), 32'd1);
    applyStimulus(1'b1, 2'd0, 1, 0, 0);

    // IRQ thresholds
    applyStimulus(1'b0, 2'd1, 12, 32'd11, 0);
    applyStimulus(1'b0, 2'd1, 14, 32'd789, 0);
    checkOutput("irq_deassert_lit", 32'(irq_de), 32'd11);
    checkOutput("irq_assert_lit", 32'(irq_as), 32'd789);
    applyStimulus(1'b1, 2'd1, 12, 0, 0);
    applyStimulus(1'b1, 2'd1, 14, 0, 0);

    // DAC codes, including the two RAM halfwords past the last DAC
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'd1, 20 + 2 * i, 32'h5aa + 32'(i), 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'd1, 20 + 2 * i, 0, 0);
    checkOutput("dac_config_7_lit", 32'(dac[7]), 32'h5b1);

    // Bias words
    applyStimulus(1'b0, 2'd2, 112, 32'h00AAAAAA, 0);
    applyStimulus(1'b0, 2'd2, 116, 32'h00BBBBBB, 0);
    applyStimulus(1'b0, 2'd2, 120, 32'h00CCCCCC, 0);
    applyStimulus(1'b0, 2'd2, 124, 32'h00DDDDDD, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd2, 112 + 4 * i, 0, 0);
    checkOutput("bias_2_lit", 32'(bias[2]), 32'h00CCCCCC);

    // FIFO count and pop strobe
    applyStimulus(1'b1, 2'd1, 16, 0, 0);
    applyStimulus(1'b1, 2'd0, 18, 0, 0);
    checkAll("directed");

    // Aborted write, then a complete one
    applyStimulus(1'b0, 2'd2, 112, 32'h12345678, 9);
    checkAll("abort");
    applyStimulus(1'b0, 2'd2, 112, 32'h99EEEEEE, 0);
    applyStimulus(1'b1, 2'd2, 112, 0, 0);
    checkAll("after_abort");

    // Random traffic across the whole map
    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    int'($urandom_range(0, 127)), $urandom, 0);
    end
    checkAll("random");
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
